// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the six-stage pipeline sequencer: PC select codes,
// sequencer state codes and stage indices (IF=0 .. WB=5).
package pipe_ctrl_pkg;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_EXC = 2'b10;
    localparam logic [1:0] PC_SEL_ERA = 2'b11;

    localparam logic [1:0] ST_INIT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_EXC_WAIT = 2'd2;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MM1 = 3;
    localparam int STG_MM2 = 4;
    localparam int STG_WB  = 5;

endpackage

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// Highest-set-bit encoder for stall requests; the most downstream
// requesting stage wins.
module stall_prio_enc #(
    parameter int NSTG  = 5,
    parameter int IDX_W = 3
) (
    input  logic [NSTG-1:0]  req,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    always_comb begin
        idx = '0;
        vld = |req;
        for (int i = 0; i < NSTG; i++) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: drives per-register wen/flush, resolves stalls, branch
// redirects and WB exceptions/ERTN, drains in-flight memory after exceptions.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTG  = STG_WB,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NSTG-1:0]  stall_req,
    input  logic             br_redirect,
    input  logic             wb_exc,
    input  logic             wb_ertn,
    input  logic             mem_outstanding,
    output logic [NSTG-1:0]  wen,
    output logic [NSTG-1:0]  flush,
    output logic [1:0]       pc_sel,
    output logic             if_hold,
    output logic             redirect_ack,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int IDX_W = (NSTG > 1) ? $clog2(NSTG) : 1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IDX_W-1:0] stall_idx;
    logic             stall_vld;
    logic             br_ok;

    stall_prio_enc #(
        .NSTG  (NSTG),
        .IDX_W (IDX_W)
    ) u_prio (
        .req (stall_req),
        .idx (stall_idx),
        .vld (stall_vld)
    );

    // A stall at EX or further downstream keeps the branch in EX; it is re-presented.
    assign br_ok = br_redirect && !(stall_vld && (stall_idx >= IDX_W'(STG_EX)));

    always_comb begin
        wen          = '1;
        flush        = '1;
        pc_sel       = PC_SEL_SEQ;
        if_hold      = 1'b1;
        redirect_ack = 1'b0;
        state_nxt    = state;
        case (state)
            ST_INIT: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (wb_exc || wb_ertn) begin
                    pc_sel  = wb_exc ? PC_SEL_EXC : PC_SEL_ERA;
                    if_hold = 1'b0;
                    if (mem_outstanding) state_nxt = ST_EXC_WAIT;
                end else begin
                    if_hold = stall_vld;
                    for (int i = 0; i < NSTG; i++) begin
                        wen[i]   = !stall_vld || (IDX_W'(i) >= stall_idx);
                        flush[i] = stall_vld && (IDX_W'(i) == stall_idx);
                    end
                    if (br_ok) begin
                        wen[STG_IF]   = 1'b1;
                        wen[STG_ID]   = 1'b1;
                        flush[STG_IF] = 1'b1;
                        flush[STG_ID] = 1'b1;
                        pc_sel        = PC_SEL_BR;
                        redirect_ack  = 1'b1;
                        if_hold       = 1'b0;
                    end
                end
            end
            ST_EXC_WAIT: begin
                if (!mem_outstanding) state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ST_RUN) && !(&wen)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, stalls, branch redirects, exceptions,
// ERTN and memory drain, with hand-computed expectations.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  stall_req;
    logic        br_redirect;
    logic        wb_exc;
    logic        wb_ertn;
    logic        mem_outstanding;
    logic [4:0]  wen;
    logic [4:0]  flush;
    logic [1:0]  pc_sel;
    logic        if_hold;
    logic        redirect_ack;
    logic [31:0] stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.NSTG(5), .CNT_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_req       (stall_req),
        .br_redirect     (br_redirect),
        .wb_exc          (wb_exc),
        .wb_ertn         (wb_ertn),
        .mem_outstanding (mem_outstanding),
        .wen             (wen),
        .flush           (flush),
        .pc_sel          (pc_sel),
        .if_hold         (if_hold),
        .redirect_ack    (redirect_ack),
        .stall_cnt       (stall_cnt)
    );

    // Observed control vector: {wen, flush, pc_sel, if_hold, redirect_ack}
    logic [13:0] ctl;
    assign ctl = {wen, flush, pc_sel, if_hold, redirect_ack};

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        stall_req       = 5'b0;
        br_redirect     = 1'b0;
        wb_exc          = 1'b0;
        wb_ertn         = 1'b0;
        mem_outstanding = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({ctl, stall_cnt} !== {14'b11111_11111_00_1_0, 32'd0})
            $display("FAIL reset_hold ctl=%b cnt=%0d exp ctl=%b cnt=0", ctl, stall_cnt, 14'b11111_11111_00_1_0);
        else n_pass++;
        rst_n = 1'b1;
        #2;
        n_chk++;
        if (ctl !== 14'b11111_11111_00_1_0)
            $display("FAIL reset_init ctl=%b exp=%b", ctl, 14'b11111_11111_00_1_0);
        else n_pass++;
        next_cycle();
        n_chk++;
        if ({ctl, stall_cnt} !== {14'b11111_00000_00_0_0, 32'd0})
            $display("FAIL reset_run ctl=%b cnt=%0d exp ctl=%b cnt=0", ctl, stall_cnt, 14'b11111_00000_00_0_0);
        else n_pass++;
    endtask

    task automatic test_nested_stall;
        stall_req = 5'b00010;
        #2;
        n_chk++;
        if (ctl !== 14'b11110_00010_00_1_0)
            $display("FAIL stall_load_use ctl=%b exp=%b", ctl, 14'b11110_00010_00_1_0);
        else n_pass++;
        next_cycle();
        stall_req = 5'b10010;
        #2;
        n_chk++;
        if (ctl !== 14'b10000_10000_00_1_0)
            $display("FAIL stall_nested ctl=%b exp=%b", ctl, 14'b10000_10000_00_1_0);
        else n_pass++;
        next_cycle();
        stall_req = 5'b0;
        #2;
        n_chk++;
        if ({ctl, stall_cnt} !== {14'b11111_00000_00_0_0, 32'd2})
            $display("FAIL stall_cnt_2 ctl=%b cnt=%0d exp ctl=%b cnt=2", ctl, stall_cnt, 14'b11111_00000_00_0_0);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_branch_downstream;
        br_redirect = 1'b1;
        stall_req   = 5'b01000;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_chk++;
            if (ctl !== 14'b11000_01000_00_1_0)
                $display("FAIL br_blocked_c%0d ctl=%b exp=%b", c, ctl, 14'b11000_01000_00_1_0);
            else n_pass++;
            next_cycle();
        end
        stall_req = 5'b0;
        #2;
        n_chk++;
        if ({ctl, stall_cnt} !== {14'b11111_00011_01_0_1, 32'd4})
            $display("FAIL br_taken ctl=%b cnt=%0d exp ctl=%b cnt=4", ctl, stall_cnt, 14'b11111_00011_01_0_1);
        else n_pass++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_branch_upstream;
        logic [4:0] up [2];
        up[0] = 5'b00001;
        up[1] = 5'b00010;
        br_redirect = 1'b1;
        for (int k = 0; k < 2; k++) begin
            stall_req = up[k];
            #2;
            n_chk++;
            if (ctl !== 14'b11111_00011_01_0_1)
                $display("FAIL br_override_%0d ctl=%b exp=%b", k, ctl, 14'b11111_00011_01_0_1);
            else n_pass++;
            next_cycle();
        end
        // s = EX is the first stall that blocks the redirect
        stall_req = 5'b00100;
        #2;
        n_chk++;
        if ({ctl, stall_cnt} !== {14'b11100_00100_00_1_0, 32'd4})
            $display("FAIL br_blocked_ex ctl=%b cnt=%0d exp ctl=%b cnt=4", ctl, stall_cnt, 14'b11100_00100_00_1_0);
        else n_pass++;
        next_cycle();
        idle_inputs();
        #2;
        n_chk++;
        if (stall_cnt !== 32'd5)
            $display("FAIL stall_cnt_5 cnt=%0d exp=5", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_exc_drain;
        // Exception beats a dcache-miss stall and a pending branch.
        wb_exc          = 1'b1;
        mem_outstanding = 1'b1;
        stall_req       = 5'b10000;
        br_redirect     = 1'b1;
        #2;
        n_chk++;
        if (ctl !== 14'b11111_11111_10_0_0)
            $display("FAIL exc_entry ctl=%b exp=%b", ctl, 14'b11111_11111_10_0_0);
        else n_pass++;
        next_cycle();
        wb_exc    = 1'b0;
        stall_req = 5'b0;
        for (int c = 1; c <= 4; c++) begin
            mem_outstanding = (c < 4);
            #2;
            n_chk++;
            if (ctl !== 14'b11111_11111_00_1_0)
                $display("FAIL exc_wait_c%0d ctl=%b exp=%b", c, ctl, 14'b11111_11111_00_1_0);
            else n_pass++;
            next_cycle();
        end
        #2;
        n_chk++;
        if ({ctl, stall_cnt} !== {14'b11111_00011_01_0_1, 32'd5})
            $display("FAIL exc_resume ctl=%b cnt=%0d exp ctl=%b cnt=5", ctl, stall_cnt, 14'b11111_00011_01_0_1);
        else n_pass++;
        next_cycle();
        idle_inputs();

        // Memory returns in the entry cycle of the wait: exactly one wait cycle.
        wb_exc          = 1'b1;
        mem_outstanding = 1'b1;
        next_cycle();
        wb_exc          = 1'b0;
        mem_outstanding = 1'b0;
        #2;
        n_chk++;
        if (ctl !== 14'b11111_11111_00_1_0)
            $display("FAIL exc_wait_one ctl=%b exp=%b", ctl, 14'b11111_11111_00_1_0);
        else n_pass++;
        next_cycle();
        #2;
        n_chk++;
        if (ctl !== 14'b11111_00000_00_0_0)
            $display("FAIL exc_wait_one_exit ctl=%b exp=%b", ctl, 14'b11111_00000_00_0_0);
        else n_pass++;
    endtask

    task automatic test_exc_ertn;
        wb_exc  = 1'b1;
        wb_ertn = 1'b1;
        #2;
        n_chk++;
        if (ctl !== 14'b11111_11111_10_0_0)
            $display("FAIL exc_and_ertn ctl=%b exp=%b", ctl, 14'b11111_11111_10_0_0);
        else n_pass++;
        next_cycle();
        wb_exc = 1'b0;
        #2;
        n_chk++;
        if (ctl !== 14'b11111_11111_11_0_0)
            $display("FAIL ertn_only ctl=%b exp=%b", ctl, 14'b11111_11111_11_0_0);
        else n_pass++;
        next_cycle();
        wb_ertn = 1'b0;
        #2;
        n_chk++;
        if (ctl !== 14'b11111_00000_00_0_0)
            $display("FAIL ertn_stays_run ctl=%b exp=%b", ctl, 14'b11111_00000_00_0_0);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset_mid_wait;
        wb_exc          = 1'b1;
        mem_outstanding = 1'b1;
        next_cycle();
        wb_exc = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({ctl, stall_cnt} !== {14'b11111_11111_00_1_0, 32'd0})
            $display("FAIL reset_mid_wait ctl=%b cnt=%0d exp ctl=%b cnt=0", ctl, stall_cnt, 14'b11111_11111_00_1_0);
        else n_pass++;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        #2;
        n_chk++;
        if (ctl !== 14'b11111_00000_00_0_0)
            $display("FAIL reset_mid_wait_run ctl=%b exp=%b", ctl, 14'b11111_00000_00_0_0);
        else n_pass++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_nested_stall();
        test_branch_downstream();
        test_branch_upstream();
        test_exc_drain();
        test_exc_ertn();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
